// File: rtl/sram_ctrl_pkg.sv
// Shared types and limits for the Wishbone-to-asynchronous-SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int AB_WIDTH_DEF = 18;
  localparam int WAIT_MIN     = 1;
  localparam int WAIT_MAX     = 15;
  localparam int CNT_W        = 4;

endpackage

// File: rtl/sram_wb_ctrl.sv
// Wishbone classic slave driving a 32-bit asynchronous SRAM with a programmable
// strobe width. All SRAM-side signals and the Wishbone responses are registered.
module sram_wb_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AB_WIDTH    = AB_WIDTH_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  CYC_I,
  input  logic                  STB_I,
  input  logic                  WE_I,
  input  logic [AB_WIDTH+1:0]   ADR_I,
  input  logic [3:0]            SEL_I,
  input  logic [31:0]           DAT_I,
  output logic [31:0]           DAT_O,
  output logic                  ACK_O,
  output logic [AB_WIDTH-1:0]   sram_addr_o,
  output logic [31:0]           sram_dat_o,
  input  logic [31:0]           sram_dat_i,
  output logic [3:0]            sram_bsel_o,
  output logic                  sram_ncs_o,
  output logic                  sram_noe_o,
  output logic                  sram_nwe_o,
  output logic [1:0]            state_o
);

  // Out-of-range WAIT_CYCLES values are clamped into the legal window.
  localparam int WAIT_EFF = (WAIT_CYCLES < WAIT_MIN) ? WAIT_MIN :
                            (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic             unused_adr;

  assign unused_adr = ^ADR_I[1:0];
  assign state_o    = state;

  // Handshake: a request is taken when CYC_I&STB_I is seen in IDLE; the master
  // must hold CYC_I until the single-cycle ACK_O and drop STB_I with it.
  // Dropping CYC_I before ACK_O abandons the access without an acknowledge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      ACK_O       <= 1'b0;
      DAT_O       <= '0;
      sram_addr_o <= '0;
      sram_dat_o  <= '0;
      sram_bsel_o <= '0;
      sram_ncs_o  <= 1'b1;
      sram_noe_o  <= 1'b1;
      sram_nwe_o  <= 1'b1;
    end else begin
      ACK_O <= 1'b0;
      case (state)
        IDLE: begin
          if (CYC_I && STB_I) begin
            sram_addr_o <= ADR_I[AB_WIDTH+1:2];
            sram_bsel_o <= SEL_I;
            sram_dat_o  <= DAT_I;
            we_q        <= WE_I;
            sram_ncs_o  <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (!CYC_I) begin
            sram_ncs_o <= 1'b1;
            sram_noe_o <= 1'b1;
            sram_nwe_o <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt        <= CNT_LOAD;
            sram_noe_o <= we_q;
            sram_nwe_o <= !we_q;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!CYC_I) begin
            sram_ncs_o <= 1'b1;
            sram_noe_o <= 1'b1;
            sram_nwe_o <= 1'b1;
            state      <= IDLE;
          end else if (cnt == '0) begin
            // Read data is taken while noe is still low, before it rises.
            if (!we_q) DAT_O <= sram_dat_i;
            sram_noe_o <= 1'b1;
            sram_nwe_o <= 1'b1;
            ACK_O      <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          sram_ncs_o <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          sram_ncs_o <= 1'b1;
          sram_noe_o <= 1'b1;
          sram_nwe_o <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// Bench for sram_wb_ctrl: two instances (WAIT_CYCLES 1 and 4), each with an
// SRAM model, checked against a word-level memory model with byte merging.
module tb_sram_wb_ctrl;
  import sram_ctrl_pkg::*;

  logic        clk;
  logic        rst       [2];
  logic        cyc       [2];
  logic        stb       [2];
  logic        we        [2];
  logic [19:0] adr       [2];
  logic [3:0]  sel       [2];
  logic [31:0] dat       [2];
  logic [31:0] dat_o     [2];
  logic        ack       [2];
  logic [17:0] sram_addr [2];
  logic [31:0] sram_dout [2];
  logic [31:0] sram_din  [2];
  logic [3:0]  bsel      [2];
  logic        ncs       [2];
  logic        noe       [2];
  logic        nwe       [2];
  logic [1:0]  st        [2];

  logic [31:0] mem   [2][1024];
  logic [31:0] model [2][1024];
  logic        mem_clear;

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_wb_ctrl #(.AB_WIDTH(18), .WAIT_CYCLES(g == 0 ? 1 : 4)) u_dut (
      .clk_i(clk), .rst_i(rst[g]), .CYC_I(cyc[g]), .STB_I(stb[g]), .WE_I(we[g]),
      .ADR_I(adr[g]), .SEL_I(sel[g]), .DAT_I(dat[g]), .DAT_O(dat_o[g]), .ACK_O(ack[g]),
      .sram_addr_o(sram_addr[g]), .sram_dat_o(sram_dout[g]), .sram_dat_i(sram_din[g]),
      .sram_bsel_o(bsel[g]), .sram_ncs_o(ncs[g]), .sram_noe_o(noe[g]),
      .sram_nwe_o(nwe[g]), .state_o(st[g])
    );
    assign sram_din[g] = (!ncs[g] && !noe[g]) ? mem[g][sram_addr[g][9:0]] : 32'h0;
  end

  // SRAM device model: byte-masked write on each clock while cs and we are low.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 1024; i++) mem[d][i] <= 32'h0;
    end else begin
      for (int d = 0; d < 2; d++)
        if (!ncs[d] && !nwe[d])
          for (int b = 0; b < 4; b++)
            if (bsel[d][b]) mem[d][sram_addr[d][9:0]][b*8 +: 8] <= sram_dout[d][b*8 +: 8];
    end
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_write(input int d, input logic [19:0] a, input logic [3:0] s,
                             input logic [31:0] wd);
    for (int b = 0; b < 4; b++)
      if (s[b]) model[d][a[11:2]][b*8 +: 8] = wd[b*8 +: 8];
  endtask

  task automatic xfer(input int d, input logic w, input logic [19:0] a, input logic [3:0] s,
                      input logic [31:0] wd, output logic [31:0] rd);
    int n, wl, rl, bad;
    logic got;
    n = 0; wl = 0; rl = 0; bad = 0; got = 1'b0; rd = 32'h0;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat[d] = wd;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (!nwe[d]) wl++;
      if (!noe[d]) rl++;
      if (!ncs[d] && (sram_addr[d] != a[19:2] || bsel[d] != s || (w && sram_dout[d] != wd)))
        bad++;
      if (ack[d]) begin
        got = 1'b1;
        rd  = dat_o[d];
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    check("ack_seen", 32'(got), 32'd1);
    check("ack_latency", 32'(n), 32'(wait_of(d) + 2));
    check("strobe_width", 32'(w ? wl : rl), 32'(wait_of(d)));
    check("other_strobe_quiet", 32'(w ? rl : wl), 32'd0);
    check("addr_sel_data_stable", 32'(bad), 32'd0);
    @(negedge clk);
    check("ack_single_cycle", 32'(ack[d]), 32'd0);
    check("ncs_back_idle", 32'(ncs[d]), 32'd1);
    if (w) model_write(d, a, s, wd);
  endtask

  typedef struct {
    int          d;
    logic        w;
    logic [19:0] a;
    logic [3:0]  s;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [31:0] rd, exp;
    int d, ack_cnt;
    logic w;
    logic [19:0] a;
    logic [3:0] s;

    mem_clear = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      adr[k] = '0; sel[k] = '0; dat[k] = '0;
      for (int i = 0; i < 1024; i++) model[k][i] = 32'h0;
    end

    // Reset values are checked before the first clock edge.
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_ncs", 32'(ncs[k]), 32'd1);
      check("rst_noe", 32'(noe[k]), 32'd1);
      check("rst_nwe", 32'(nwe[k]), 32'd1);
      check("rst_ack", 32'(ack[k]), 32'd0);
      check("rst_dat_o", dat_o[k], 32'h0);
      check("rst_addr", 32'(sram_addr[k]), 32'h0);
      check("rst_sram_dat", sram_dout[k], 32'h0);
      check("rst_bsel", 32'(bsel[k]), 32'h0);
      check("rst_state", 32'(st[k]), 32'(IDLE));
    end
    repeat (2) @(negedge clk);
    mem_clear = 1'b0;
    rst[0] = 1'b0; rst[1] = 1'b0;

    vt[0] = '{0, 1'b1, 20'h00010, 4'hF, 32'hDEADBEEF, 32'h0};
    vt[1] = '{0, 1'b0, 20'h00010, 4'hF, 32'h0,        32'hDEADBEEF};
    vt[2] = '{0, 1'b1, 20'h00010, 4'h4, 32'h00AA0000, 32'h0};
    vt[3] = '{0, 1'b0, 20'h00010, 4'hF, 32'h0,        32'hDEAABEEF};
    vt[4] = '{1, 1'b1, 20'h00020, 4'hF, 32'h12345678, 32'h0};
    vt[5] = '{1, 1'b0, 20'h00020, 4'hF, 32'h0,        32'h12345678};
    vt[6] = '{1, 1'b1, 20'h00020, 4'h0, 32'hFFFFFFFF, 32'h0};
    vt[7] = '{1, 1'b0, 20'h00020, 4'hF, 32'h0,        32'h12345678};

    for (int i = 0; i < 8; i++) begin
      xfer(vt[i].d, vt[i].w, vt[i].a, vt[i].s, vt[i].wd, rd);
      if (!vt[i].w) check("vec_read", rd, vt[i].exp);
    end

    // Random traffic against the memory model.
    for (int i = 0; i < 160; i++) begin
      d = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = {8'h00, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
      s = 4'($urandom_range(0, 15));
      exp = model[d][a[11:2]];
      xfer(d, w, a, s, $urandom, rd);
      if (!w) check("rand_read", rd, exp);
    end

    // Read abandoned in ACCESS on the slow instance.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 20'h00020; sel[1] = 4'hF;
    repeat (3) @(negedge clk);
    check("abort_rd_in_access", 32'(noe[1]), 32'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    check("abort_rd_strobes", 32'({ncs[1], noe[1], nwe[1]}), 32'b111);
    ack_cnt = 0;
    repeat (6) begin
      if (ack[1]) ack_cnt++;
      @(negedge clk);
    end
    check("abort_rd_no_ack", 32'(ack_cnt), 32'd0);

    // Write abandoned in SETUP must leave memory untouched.
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 20'h00010; sel[0] = 4'hF;
    dat[0] = 32'h0;
    @(negedge clk);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    check("abort_wr_strobes", 32'({ncs[0], noe[0], nwe[0]}), 32'b111);
    ack_cnt = 0;
    repeat (4) begin
      if (ack[0]) ack_cnt++;
      @(negedge clk);
    end
    check("abort_wr_no_ack", 32'(ack_cnt), 32'd0);
    exp = model[0][4];
    xfer(0, 1'b0, 20'h00010, 4'hF, 32'h0, rd);
    check("abort_mem_unchanged", rd, exp);

    // Asynchronous reset in the middle of a write.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 20'h00040; sel[1] = 4'hF;
    dat[1] = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    check("midwr_nwe_low", 32'(nwe[1]), 32'd0);
    #2 rst[1] = 1'b1;
    #1;
    check("midwr_rst_strobes", 32'({ncs[1], noe[1], nwe[1]}), 32'b111);
    check("midwr_rst_ack", 32'(ack[1]), 32'd0);
    check("midwr_rst_state", 32'(st[1]), 32'(IDLE));
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    model_write(1, 20'h00040, 4'hF, 32'hCAFEF00D);
    ack_cnt = 0;
    repeat (3) begin
      if (ack[1]) ack_cnt++;
      @(negedge clk);
    end
    check("midwr_no_ack", 32'(ack_cnt), 32'd0);
    xfer(1, 1'b1, 20'h00044, 4'hF, 32'h0BADCAFE, rd);
    xfer(1, 1'b0, 20'h00044, 4'hF, 32'h0, rd);
    check("post_rst_read", rd, 32'h0BADCAFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL timeout: bench did not complete, %0d checks done", tests);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_wb_ctrl.md
SRAM_WB_CTRL -- requirements
Module: sram_wb_ctrl

Interface
REQ-001 Parameter AB_WIDTH, default 18: SRAM word-address width (256k x 32).
REQ-002 Parameter WAIT_CYCLES, default 1: strobe-active cycles per access; legal range 1..15.
REQ-003 clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 CYC_I  in  1  Wishbone cycle valid.
REQ-006 STB_I  in  1  Wishbone strobe.
REQ-007 WE_I  in  1  1 = write, 0 = read.
REQ-008 ADR_I  in  AB_WIDTH+2  byte address; bits [1:0] are ignored.
REQ-009 SEL_I  in  4  byte lane selects; bit 3 = bits [31:24].
REQ-010 DAT_I  in  32  write data.
REQ-011 DAT_O  out  32  registered read data.
REQ-012 ACK_O  out  1  one-cycle transfer acknowledge.
REQ-013 sram_addr_o  out  AB_WIDTH  SRAM word address.
REQ-014 sram_dat_o  out  32  data to SRAM.
REQ-015 sram_dat_i  in  32  data from SRAM.
REQ-016 sram_bsel_o  out  4  byte selects, active-high.
REQ-017 sram_ncs_o, sram_noe_o, sram_nwe_o  out  1 each  chip select, output enable and write enable, all active-low.

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS, DONE; every SRAM output is a register.
REQ-019 IDLE: on CYC_I&STB_I, latch ADR_I[AB_WIDTH+1:2], SEL_I, WE_I and DAT_I into sram_addr_o, sram_bsel_o, the internal write flag and sram_dat_o; go to SETUP.
REQ-020 SETUP (1 cycle): sram_ncs_o=0; noe and nwe stay 1; load the wait counter with WAIT_CYCLES-1; go to ACCESS.
REQ-021 ACCESS: ncs=0; write drives nwe=0, read drives noe=0; decrement the counter each cycle; at 0 go to DONE.
REQ-022 DONE: nwe=1 and noe=1, ncs stays 0, ACK_O=1 for this cycle only.
REQ-023 DONE, read: DAT_O captures sram_dat_i on the ACCESS-to-DONE edge and holds it until the next read completes.
REQ-024 DONE -> IDLE unconditionally; ncs=1 in IDLE.
REQ-025 Latency: the request is sampled at edge N and ACK_O is high in cycle N+2+WAIT_CYCLES; there is no back-to-back acceptance.
REQ-026 Address, select and data outputs stay stable from SETUP through DONE.
REQ-027 CYC_I low in SETUP or ACCESS aborts: next state IDLE, all strobes deassert, no ACK_O.
REQ-028 A read never toggles nwe; a write never toggles noe.
REQ-029 SEL_I=0 still runs a full cycle and acknowledges, with bsel=0.

Reset
REQ-030 rst_i asserted forces IDLE with no clock required.
REQ-031 rst_i asserted sets ncs, noe and nwe to 1, and ACK_O, DAT_O, sram_addr_o, sram_dat_o, sram_bsel_o and the counter to 0.
REQ-032 Reset in mid-access ends the access immediately with no ACK_O; the first request after release behaves as from cold.

Structure
REQ-033 Package sram_ctrl_pkg holds the state enum, the default AB_WIDTH and the WAIT_CYCLES limits.
REQ-034 Single flat module; the wait counter is inline, with no sub-module.

Verification
REQ-035 Write: WAIT_CYCLES=1, ADR_I=0x00010, SEL_I=0xF, DAT_I=0xDEADBEEF -> nwe low exactly one cycle with sram_addr_o=0x00004, then ACK_O in cycle N+3.
REQ-036 Readback of REQ-035 -> noe low one cycle, then DAT_O=0xDEADBEEF with ACK_O; nwe stays 1 throughout.
REQ-037 Byte write with SEL_I=0x4, DAT_I=0x00AA0000 to the same address, then read -> 0xDEAABEEF.
REQ-038 WAIT_CYCLES=4 read -> noe low exactly 4 cycles, then ACK_O in cycle N+6.
REQ-039 CYC_I dropped during ACCESS -> strobes go high the next cycle, no ACK_O, memory unchanged.
REQ-040 rst_i pulsed asynchronously mid-write -> ncs, nwe and noe go to 1 with no clock edge, no ACK_O; the next request completes normally.
